// File: rtl/ps2_command_sequencer_if.sv
// Handshake bundle between a command requester, the PS/2 sequencer, the host-to-device
// transmitter and the PS/2 receive path; the slave modport is the sequencer's view.
interface ps2_command_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_opcode;
    logic       req_has_arg;
    logic [7:0] req_arg;
    logic [7:0] the_command;
    logic       send_command;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       busy;
    logic       done;
    logic [1:0] status;

    modport master (
        output req_valid, req_opcode, req_has_arg, req_arg,
        output command_was_sent, error_communication_timed_out,
        output received_data, received_data_en,
        input  req_ready, the_command, send_command, busy, done, status
    );

    modport slave (
        input  req_valid, req_opcode, req_has_arg, req_arg,
        input  command_was_sent, error_communication_timed_out,
        input  received_data, received_data_en,
        output req_ready, the_command, send_command, busy, done, status
    );
endinterface

// File: rtl/ps2_command_sequencer.sv
// Sends a PS/2 opcode (plus optional argument byte), waits for 0xFA per byte and reports one status.
// Send starts two cycles after acceptance; new requests are held off while busy. PS2_SEQ_RETRY_EN adds 0xFE resends.
module ps2_command_sequencer #(
    parameter int unsigned ACK_TIMEOUT_CYCLES = 1000000,
    parameter int unsigned ACK_TIMER_BITS     = 20,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    ps2_command_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_SEND, S_WAIT_ACK, S_DONE
    } state_e;

    localparam logic [7:0] BYTE_ACK    = 8'hFA;
    localparam logic [7:0] BYTE_RESEND = 8'hFE;
    localparam logic [ACK_TIMER_BITS-1:0] TIMER_LIMIT = ACK_TIMER_BITS'(ACK_TIMEOUT_CYCLES);
    localparam logic [ACK_TIMER_BITS-1:0] TIMER_MAX   = '1;
    localparam logic [ACK_TIMER_BITS-1:0] TIMER_ONE   = ACK_TIMER_BITS'(1);

    state_e                    state_q, state_d;
    logic [7:0]                cmd_q, cmd_d;
    logic [7:0]                arg_q, arg_d;
    logic                      has_arg_q, has_arg_d;
    logic                      phase_q, phase_d;    // 0: opcode byte, 1: argument byte
    logic [ACK_TIMER_BITS-1:0] timer_q, timer_d;
    logic [1:0]                status_q, status_d;

`ifdef PS2_SEQ_RETRY_EN
    localparam int unsigned RETRY_BITS = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RETRY_BITS-1:0] RETRY_LIMIT = RETRY_BITS'(MAX_RETRIES);
    localparam logic [RETRY_BITS-1:0] RETRY_ONE   = RETRY_BITS'(1);
    logic [RETRY_BITS-1:0] retries_q, retries_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= 8'h00;
            arg_q     <= 8'h00;
            has_arg_q <= 1'b0;
            phase_q   <= 1'b0;
            timer_q   <= '0;
            status_q  <= 2'd0;
`ifdef PS2_SEQ_RETRY_EN
            retries_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            arg_q     <= arg_d;
            has_arg_q <= has_arg_d;
            phase_q   <= phase_d;
            timer_q   <= timer_d;
            status_q  <= status_d;
`ifdef PS2_SEQ_RETRY_EN
            retries_q <= retries_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        arg_d     = arg_q;
        has_arg_d = has_arg_q;
        phase_d   = phase_q;
        timer_d   = timer_q;
        status_d  = status_q;
`ifdef PS2_SEQ_RETRY_EN
        retries_d = retries_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    cmd_d     = bus.req_opcode;
                    arg_d     = bus.req_arg;
                    has_arg_d = bus.req_has_arg;
                    phase_d   = 1'b0;
`ifdef PS2_SEQ_RETRY_EN
                    retries_d = '0;
`endif
                    state_d   = S_ARM;
                end
            end
            // Only raise the request once the transmitter has dropped both status flags.
            S_ARM: begin
                if (!bus.command_was_sent && !bus.error_communication_timed_out)
                    state_d = S_SEND;
            end
            S_SEND: begin
                if (bus.command_was_sent) begin
                    timer_d = '0;
                    state_d = S_WAIT_ACK;
                end else if (bus.error_communication_timed_out) begin
                    status_d = 2'd1;
                    state_d  = S_DONE;
                end
            end
            S_WAIT_ACK: begin
                timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_ONE;
                if (bus.received_data_en && bus.received_data == BYTE_ACK) begin
                    if (!phase_q && has_arg_q) begin
                        phase_d = 1'b1;
                        cmd_d   = arg_q;
`ifdef PS2_SEQ_RETRY_EN
                        retries_d = '0;
`endif
                        state_d = S_ARM;
                    end else begin
                        status_d = 2'd0;
                        state_d  = S_DONE;
                    end
                end else if (bus.received_data_en && bus.received_data == BYTE_RESEND) begin
`ifdef PS2_SEQ_RETRY_EN
                    if (retries_q < RETRY_LIMIT) begin
                        retries_d = retries_q + RETRY_ONE;
                        state_d   = S_ARM;
                    end else begin
                        status_d = 2'd3;
                        state_d  = S_DONE;
                    end
`else
                    status_d = 2'd3;
                    state_d  = S_DONE;
`endif
                end else if (timer_q == TIMER_LIMIT) begin
                    status_d = 2'd2;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready    = (state_q == S_IDLE);
        bus.busy         = (state_q != S_IDLE);
        bus.done         = (state_q == S_DONE);
        bus.send_command = (state_q == S_SEND);
        bus.the_command  = cmd_q;
        bus.status       = status_q;
    end
endmodule

// File: tb/tb_ps2_command_sequencer.sv
// Directed bench for ps2_command_sequencer with a transmitter/receiver model and byte/status scoreboards.
`timescale 1ns/1ps
module tb_ps2_command_sequencer;
    localparam int T    = 100;
    localparam int MAXR = 2;
`ifdef PS2_SEQ_RETRY_EN
    localparam int NAK_BURSTS = MAXR + 1;
`else
    localparam int NAK_BURSTS = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ps2_command_sequencer_if bus();

    ps2_command_sequencer #(
        .ACK_TIMEOUT_CYCLES(T),
        .ACK_TIMER_BITS(8),
        .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_bytes[$];
    logic [1:0] exp_status[$];
    int  bursts = 0;
    int  done_cnt = 0;
    int  low_run = 0;
    time first_rise = 0, last_fall = 0, last_done = 0;
    logic send_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: bursts are scored against queued bytes, done pulses against queued status.
    always @(negedge clk) begin
        if (bus.send_command && !send_prev) begin
            if (bursts > 0) check("gap_ge_2", 32'(low_run >= 2), 32'd1);
            bursts++;
            if (bursts == 1) first_rise = $time;
            if (exp_bytes.size() == 0) check("unexpected_burst", 32'(exp_bytes.size()), 32'd1);
            else check("the_command", 32'(bus.the_command), 32'(exp_bytes.pop_front()));
        end
        if (!bus.send_command && send_prev) last_fall = $time;
        low_run = bus.send_command ? 0 : low_run + 1;
        if (bus.done === 1'b1) begin
            done_cnt++;
            last_done = $time;
            if (exp_status.size() == 0) check("unexpected_done", 32'(exp_status.size()), 32'd1);
            else check("status", 32'(bus.status), 32'(exp_status.pop_front()));
        end
        send_prev = bus.send_command;
    end

    // Transmitter and receiver model: sent/error 3 cycles into a burst, reply 4 cycles into WAIT_ACK.
    int tx_cnt = 0, rx_cnt = 0, rx_mode = 0;
    bit rx_pending = 0, tx_fail = 0;
    always @(negedge clk) begin
        bus.received_data_en = 1'b0;
        if (reset) begin
            tx_cnt = 0;
            rx_pending = 0;
            bus.command_was_sent = 1'b0;
            bus.error_communication_timed_out = 1'b0;
        end else if (!bus.send_command) begin
            if (bus.command_was_sent) begin
                rx_pending = 1;
                rx_cnt = 0;
            end
            bus.command_was_sent = 1'b0;
            bus.error_communication_timed_out = 1'b0;
            tx_cnt = 0;
        end else if (!bus.command_was_sent && !bus.error_communication_timed_out) begin
            tx_cnt++;
            if (tx_cnt == 3) begin
                if (tx_fail) bus.error_communication_timed_out = 1'b1;
                else bus.command_was_sent = 1'b1;
            end
        end
        if (rx_pending) begin
            rx_cnt++;
            if (rx_mode == 0 && rx_cnt == 4) begin
                bus.received_data = 8'hFA; bus.received_data_en = 1'b1; rx_pending = 0;
            end else if (rx_mode == 1 && rx_cnt == 4) begin
                bus.received_data = 8'hFE; bus.received_data_en = 1'b1; rx_pending = 0;
            end else if (rx_mode == 2 && rx_cnt == 10) begin
                bus.received_data = 8'h1C; bus.received_data_en = 1'b1; rx_pending = 0;
            end
        end
    end

    time t_req;

    task automatic issue(input logic [7:0] op, input logic ha, input logic [7:0] a);
        bursts = 0;
        check("req_ready_before", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_opcode = op;
        bus.req_has_arg = ha;
        bus.req_arg = a;
        t_req = $time;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_count"}, 32'(done_cnt - start), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_opcode = 8'h00;
        bus.req_has_arg = 1'b0;
        bus.req_arg = 8'h00;
        bus.received_data = 8'h00;
        bus.received_data_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_send_command", 32'(bus.send_command), 32'd0);
        check("rst_the_command", 32'(bus.the_command), 32'h00);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_status", 32'(bus.status), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single opcode, ACKed.
        exp_bytes.push_back(8'hF4);
        exp_status.push_back(2'd0);
        issue(8'hF4, 1'b0, 8'h00);
        wait_done(100, "f4");
        check("f4_bursts", 32'(bursts), 32'd1);
        check("f4_first_send_latency", 32'(first_rise - t_req), 32'd20);
        repeat (5) @(negedge clk);
        check("f4_status_hold", 32'(bus.status), 32'd0);
        check("f4_idle_busy", 32'(bus.busy), 32'd0);

        // Opcode plus argument, both ACKed.
        exp_bytes.push_back(8'hED);
        exp_bytes.push_back(8'h07);
        exp_status.push_back(2'd0);
        issue(8'hED, 1'b1, 8'h07);
        wait_done(200, "ed07");
        check("ed07_bursts", 32'(bursts), 32'd2);

        // Transmitter timeout.
        tx_fail = 1;
        exp_bytes.push_back(8'hF3);
        exp_status.push_back(2'd1);
        issue(8'hF3, 1'b1, 8'h20);
        wait_done(100, "txto");
        repeat (10) @(negedge clk);
        check("txto_bursts", 32'(bursts), 32'd1);
        check("txto_status_hold", 32'(bus.status), 32'd1);
        tx_fail = 0;

        // No ACK; a scan code mid-wait must not end it. Done lands T+1 cycles after the first WAIT_ACK cycle.
        rx_mode = 2;
        exp_bytes.push_back(8'hF2);
        exp_status.push_back(2'd2);
        issue(8'hF2, 1'b0, 8'h00);
        wait_done(400, "ackto");
        check("ackto_bursts", 32'(bursts), 32'd1);
        check("ackto_latency", 32'(last_done - last_fall), 32'((T + 1) * 10));

        // Device keeps asking for a resend.
        rx_mode = 1;
        for (int i = 0; i < NAK_BURSTS; i++) exp_bytes.push_back(8'hF5);
        exp_status.push_back(2'd3);
        issue(8'hF5, 1'b0, 8'h00);
        wait_done(300, "nak");
        check("nak_bursts", 32'(bursts), 32'(NAK_BURSTS));

        // Reset while SEND is active, then a normal request.
        rx_mode = 0;
        exp_bytes.push_back(8'hEE);
        issue(8'hEE, 1'b0, 8'h00);
        n = 0;
        while (bursts == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reached_send", 32'(bus.send_command), 32'd1);
        n = done_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_send_command", 32'(bus.send_command), 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_no_done", 32'(done_cnt - n), 32'd0);
        exp_bytes.push_back(8'hF4);
        exp_status.push_back(2'd0);
        issue(8'hF4, 1'b0, 8'h00);
        wait_done(100, "after_rst");
        check("after_rst_bursts", 32'(bursts), 32'd1);

        check("bytes_left", 32'(exp_bytes.size()), 32'd0);
        check("status_left", 32'(exp_status.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
